// File: rtl/mod_case_prio_arbiter_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_case_pkg
// Description : Shared state encoding for the case-statement priority arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_case_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } arb_state_e;

    localparam logic [1:0] ARB_STATE_ILLEGAL = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mod_case_prio_arbiter_fsm_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : mod_case_prio_enc
// Description : Masked lowest-index priority encoder (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module mod_case_prio_enc #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [NUM_CH-1:0] i_mask,
    output logic              o_found,
    output logic [ID_W-1:0]   o_idx,
    output logic [NUM_CH-1:0] o_onehot
);

    logic [NUM_CH-1:0] w_active;

    assign w_active = i_req & ~i_mask;

    // Scan from the top so the lowest active index is the last one written.
    always_comb begin
        o_found  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                o_found     = 1'b1;
                o_idx       = ID_W'(i);
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mod_case_prio_arbiter_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mod_case_prio_arbiter_fsm
// Description : N-channel priority arbiter FSM with hold limit, timeout mask,
//               cooldown and illegal-state recovery. Optional macro
//               CASE_CHECK_EN enables the sticky out_case_err flag and checks.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_case_prio_arbiter_fsm
    import mod_case_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int HOLD_MAX = 8,
    parameter int COOL_CYC = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         in_req,
    input  logic                      in_release,
    output logic [NUM_CH-1:0]         out_grant,
    output logic [$clog2(NUM_CH)-1:0] out_grant_id,
    output logic                      out_valid,
    output logic                      out_timeout,
    output logic [1:0]                out_state,
    output logic                      out_case_err
);

    localparam int ID_W   = $clog2(NUM_CH);
    localparam int HOLD_W = $clog2(HOLD_MAX);
    localparam int COOL_W = $clog2(COOL_CYC + 1);

    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_MAX - 1);
    localparam logic [COOL_W-1:0] c_cool_last = COOL_W'(COOL_CYC - 1);

    logic [1:0]        r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [COOL_W-1:0] r_cool_cnt;
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] r_grant;
    logic [ID_W-1:0]   r_grant_id;
    logic              r_timeout;

    arb_state_e        w_state_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [COOL_W-1:0] w_cool_nxt;
    logic [NUM_CH-1:0] w_mask_nxt;
    logic [NUM_CH-1:0] w_grant_nxt;
    logic [ID_W-1:0]   w_grant_id_nxt;
    logic              w_timeout_nxt;

    logic              w_found;
    logic [ID_W-1:0]   w_idx;
    logic [NUM_CH-1:0] w_onehot;
    logic              w_release;
    logic              w_expire;

    mod_case_prio_enc #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_prio_enc (
        .i_req    (in_req),
        .i_mask   (r_mask),
        .o_found  (w_found),
        .o_idx    (w_idx),
        .o_onehot (w_onehot)
    );

    assign w_release = in_release | ~in_req[r_grant_id];
    assign w_expire  = (r_hold_cnt == c_hold_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_cool_cnt <= '0;
            r_mask     <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_cool_cnt <= w_cool_nxt;
            r_mask     <= w_mask_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        unique case (r_state)
            IDLE:    w_state_nxt = w_found ? GRANT : IDLE;
            GRANT:   w_state_nxt = (w_release || w_expire) ? COOL : GRANT;
            COOL:    w_state_nxt = (r_cool_cnt == c_cool_last) ? IDLE : COOL;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Release takes precedence over expiry: no timeout pulse, no mask.
    always_comb begin
        w_hold_nxt     = '0;
        w_cool_nxt     = '0;
        w_mask_nxt     = r_mask;
        w_grant_nxt    = '0;
        w_grant_id_nxt = '0;
        w_timeout_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_req != '0) begin
                    w_mask_nxt = '0;
                end
                if (w_found) begin
                    w_grant_nxt    = w_onehot;
                    w_grant_id_nxt = w_idx;
                end
            end
            GRANT: begin
                if (!w_release) begin
                    if (w_expire) begin
                        w_timeout_nxt = 1'b1;
                        w_mask_nxt    = r_grant;
                    end else begin
                        w_grant_nxt    = r_grant;
                        w_grant_id_nxt = r_grant_id;
                        w_hold_nxt     = r_hold_cnt + HOLD_W'(1);
                    end
                end
            end
            COOL: begin
                if (r_cool_cnt != c_cool_last) begin
                    w_cool_nxt = r_cool_cnt + COOL_W'(1);
                end
            end
            default: w_mask_nxt = '0;
        endcase
    end

    assign out_grant    = r_grant;
    assign out_grant_id = r_grant_id;
    assign out_valid    = (r_state == GRANT);
    assign out_timeout  = r_timeout;
    assign out_state    = r_state;

`ifdef CASE_CHECK_EN
    logic r_case_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_case_err <= 1'b0;
        end else if ((r_state == ARB_STATE_ILLEGAL) ||
                     ((r_grant & (r_grant - NUM_CH'(1))) != '0)) begin
            r_case_err <= 1'b1;
        end
    end

    assign out_case_err = r_case_err;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        (r_grant & (r_grant - NUM_CH'(1))) == '0);

    a_mask_clear: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == IDLE && in_req != '0) |=> (r_mask == '0));
`else
    assign out_case_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_case_prio_arbiter_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_case_prio_arbiter_fsm
// Description : Scoreboard bench for the priority arbiter FSM (4 ch, hold 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_case_prio_arbiter_fsm;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_req;
    logic       in_release;
    logic [3:0] out_grant;
    logic [1:0] out_grant_id;
    logic       out_valid;
    logic       out_timeout;
    logic [1:0] out_state;
    logic       out_case_err;

    int checks   = 0;
    int failures = 0;

`ifdef CASE_CHECK_EN
    localparam logic c_err_after_illegal = 1'b1;
`else
    localparam logic c_err_after_illegal = 1'b0;
`endif

    typedef struct {
        logic [3:0] grant;
        logic [1:0] id;
        int         len;
        logic       to;
    } exp_t;

    exp_t exp_q[$];

    mod_case_prio_arbiter_fsm #(
        .NUM_CH   (4),
        .HOLD_MAX (8),
        .COOL_CYC (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_req       (in_req),
        .in_release   (in_release),
        .out_grant    (out_grant),
        .out_grant_id (out_grant_id),
        .out_valid    (out_valid),
        .out_timeout  (out_timeout),
        .out_state    (out_state),
        .out_case_err (out_case_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_grant(input logic [3:0] g, input logic [1:0] id, input int len, input logic to);
        exp_t e;
        e.grant = g;
        e.id    = id;
        e.len   = len;
        e.to    = to;
        exp_q.push_back(e);
    endtask

    // Monitor: a grant starts on a rising out_valid and ends on its fall.
    initial begin
        bit   prev_valid;
        int   len;
        exp_t cur;
        prev_valid = 1'b0;
        len        = 0;
        cur.grant  = '0;
        cur.id     = '0;
        cur.len    = 0;
        cur.to     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                len        = 0;
            end else begin
                if (out_valid) begin
                    check("mon_onehot_id", 32'(out_grant), 32'(4'b0001 << out_grant_id));
                    if (!prev_valid) begin
                        if (exp_q.size() == 0) begin
                            check("mon_unexpected_grant", 32'(out_grant), 32'h0);
                        end else begin
                            cur = exp_q.pop_front();
                            check("mon_grant", 32'(out_grant), 32'(cur.grant));
                            check("mon_grant_id", 32'(out_grant_id), 32'(cur.id));
                        end
                        len = 1;
                    end else begin
                        len++;
                    end
                end else if (prev_valid) begin
                    check("mon_hold_len", 32'(len), 32'(cur.len));
                    check("mon_timeout", 32'(out_timeout), 32'(cur.to));
                end else if (out_timeout) begin
                    check("mon_stray_timeout", 32'(out_timeout), 32'h0);
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_req     = 4'b1111;
        in_release = 1'b0;
        cyc(2);
        check("rst_grant", 32'(out_grant), 32'h0);
        check("rst_id", 32'(out_grant_id), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_timeout", 32'(out_timeout), 32'h0);
        check("rst_state", 32'(out_state), 32'h0);
        check("rst_case_err", 32'(out_case_err), 32'h0);

        // Reset release with all requests: ch0 wins one cycle later
        expect_grant(4'b0001, 2'd0, 1, 1'b0);
        #2 rst_n = 1'b1;
        cyc(1);
        check("first_grant", 32'(out_grant), 32'h1);
        check("first_valid", 32'(out_valid), 32'h1);
        in_req = 4'b0000;
        cyc(3);

        // Priority and release by dropping the request
        expect_grant(4'b0100, 2'd2, 2, 1'b0);
        expect_grant(4'b1000, 2'd3, 1, 1'b0);
        in_req = 4'b1100;
        cyc(2);
        in_req = 4'b1000;
        cyc(1);
        check("prio_cool_state", 32'(out_state), 32'h2);
        cyc(1);
        check("prio_idle_state", 32'(out_state), 32'h0);
        cyc(1);
        in_req = 4'b0000;
        cyc(3);

        // Timeout masks ch0 for one arbitration
        expect_grant(4'b0001, 2'd0, 8, 1'b1);
        expect_grant(4'b0010, 2'd1, 2, 1'b0);
        expect_grant(4'b0001, 2'd0, 1, 1'b0);
        in_req = 4'b0011;
        cyc(9);
        check("to_pulse", 32'(out_timeout), 32'h1);
        check("to_cool_state", 32'(out_state), 32'h2);
        cyc(2);
        check("to_masked_next", 32'(out_grant), 32'h2);
        cyc(1);
        in_release = 1'b1;
        cyc(1);
        in_release = 1'b0;
        cyc(2);
        check("to_regrant_ch0", 32'(out_grant), 32'h1);
        in_req = 4'b0000;
        cyc(3);

        // Only the masked channel requests: one idle arbitration first
        expect_grant(4'b0001, 2'd0, 8, 1'b1);
        expect_grant(4'b0001, 2'd0, 1, 1'b0);
        in_req = 4'b0001;
        cyc(11);
        check("mask_wait_valid", 32'(out_valid), 32'h0);
        check("mask_wait_state", 32'(out_state), 32'h0);
        cyc(1);
        check("mask_wait_grant", 32'(out_valid), 32'h1);
        in_req = 4'b0000;
        cyc(3);

        // Release on the expiry cycle wins: no timeout, no mask
        expect_grant(4'b0001, 2'd0, 8, 1'b0);
        expect_grant(4'b0001, 2'd0, 1, 1'b0);
        in_req = 4'b0001;
        cyc(8);
        in_release = 1'b1;
        cyc(1);
        in_release = 1'b0;
        check("simul_no_timeout", 32'(out_timeout), 32'h0);
        cyc(2);
        check("simul_regrant", 32'(out_grant), 32'h1);
        check("simul_regrant_valid", 32'(out_valid), 32'h1);
        in_req = 4'b0000;
        cyc(3);

        // Asynchronous reset between clock edges
        expect_grant(4'b0010, 2'd1, 0, 1'b0);
        in_req = 4'b0010;
        cyc(2);
        check("async_pre_valid", 32'(out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_grant", 32'(out_grant), 32'h0);
        check("async_id", 32'(out_grant_id), 32'h0);
        check("async_valid", 32'(out_valid), 32'h0);
        check("async_state", 32'(out_state), 32'h0);
        in_req = 4'b0000;
        cyc(1);
        #2 rst_n = 1'b1;
        cyc(2);

        // Illegal state recovery
        expect_grant(4'b0100, 2'd2, 1, 1'b0);
        in_req = 4'b0100;
        cyc(1);
        in_req = 4'b0000;
        #1 force dut.r_state = 2'd3;
        #1;
        check("illegal_state", 32'(out_state), 32'h3);
        check("illegal_valid", 32'(out_valid), 32'h0);
        release dut.r_state;
        cyc(1);
        check("recover_state", 32'(out_state), 32'h0);
        check("recover_grant", 32'(out_grant), 32'h0);
        check("recover_id", 32'(out_grant_id), 32'h0);
        check("recover_case_err", 32'(out_case_err), 32'(c_err_after_illegal));
        cyc(2);
        check("case_err_sticky", 32'(out_case_err), 32'(c_err_after_illegal));

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
